// File: rtl/core_pkg.sv
// core_pkg: definitions shared across the RV32I core.
//   - datapath width, register count and register index type
//   - writeback-select encodings, used by both the writeback mux and the register file
package core_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_MEM = 2'h0,
        WB_ALU = 2'h1,
        WB_PC4 = 2'h2
    } wb_sel_t;

endpackage

// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if: groups the read, writeback and scoreboard signals of the register file.
//   master  : decode/execute + writeback side (drives indices, write and load-issue strobes)
//   slave   : register file (returns read data, stall and the busy vector)
interface reg_file_wb_if;
    import core_pkg::*;

    reg_idx_t              io_rs1_addr;
    reg_idx_t              io_rs2_addr;
    logic [XLEN-1:0]       io_rs1_data;
    logic [XLEN-1:0]       io_rs2_data;
    logic                  io_wr_en;
    reg_idx_t              io_wr_addr;
    logic [XLEN-1:0]       io_wr_data;
    logic                  io_busy_set;
    reg_idx_t              io_busy_addr;
    logic                  io_flush;
    logic                  io_stall;
    logic [NREGS-1:0]      io_busy_vec;

    modport master (
        output io_rs1_addr, io_rs2_addr, io_wr_en, io_wr_addr, io_wr_data,
               io_busy_set, io_busy_addr, io_flush,
        input  io_rs1_data, io_rs2_data, io_stall, io_busy_vec
    );

    modport slave (
        input  io_rs1_addr, io_rs2_addr, io_wr_en, io_wr_addr, io_wr_data,
               io_busy_set, io_busy_addr, io_flush,
        output io_rs1_data, io_rs2_data, io_stall, io_busy_vec
    );

endinterface

// File: rtl/reg_file_wb_scoreboard.sv
// reg_scoreboard: one pending-load bit per register plus the load-use stall compare.
//   Ports: clock/reset (sync, active-high); i_flush, i_busy_set/i_busy_addr (load issue),
//   i_wr_en/i_wr_addr (writeback), i_rs1_addr/i_rs2_addr (decode sources);
//   o_stall (source operand pending), o_busy_vec (bit 0 always 0).
// Optional macro REGFILE_BYPASS_EN: a register being written back this cycle is
// treated as not busy for the stall, releasing a load-use stall one cycle earlier.
module reg_scoreboard
    import core_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_busy_set,
    input  reg_idx_t         i_busy_addr,
    input  logic             i_wr_en,
    input  reg_idx_t         i_wr_addr,
    input  reg_idx_t         i_rs1_addr,
    input  reg_idx_t         i_rs2_addr,
    output logic             o_stall,
    output logic [NREGS-1:0] o_busy_vec
);

    // x0 has no flop: it can never be pending.
    logic [NREGS-1:1] r_busy;
    logic [NREGS-1:0] w_busy_eff;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= '0;
        end else if (i_flush) begin
            // flush discards every mark, including a load issued this same cycle
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                // a newly issued load wins over the older load's writeback clear
                if (i_busy_set && i_busy_addr == REG_IDX_W'(i))
                    r_busy[i] <= 1'b1;
                else if (i_wr_en && i_wr_addr == REG_IDX_W'(i))
                    r_busy[i] <= 1'b0;
            end
        end
    end

    assign o_busy_vec = {r_busy, 1'b0};

    always_comb begin
        w_busy_eff = {r_busy, 1'b0};
`ifdef REGFILE_BYPASS_EN
        if (i_wr_en)
            w_busy_eff[i_wr_addr] = 1'b0;
`endif
    end

    assign o_stall = (w_busy_eff[i_rs1_addr] && i_rs1_addr != REG_ZERO) ||
                     (w_busy_eff[i_rs2_addr] && i_rs2_addr != REG_ZERO);

endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: RV32I integer register file at the end of the writeback path.
//   Ports: clock, reset (sync, active-high); bus (reg_file_wb_if.slave) carrying two
//   combinational read ports, the writeback port, load-issue/flush scoreboard inputs,
//   and the stall / busy-vector outputs.
//   x0 reads as zero and ignores writes. A write is visible to reads the next cycle.
// Optional macro REGFILE_BYPASS_EN: a read of the index being written this cycle
// returns the incoming writeback word (write-through), and the stall releases with it.
module reg_file_wb
    import core_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    reg_file_wb_if.slave  bus
);

    logic [XLEN-1:0] r_mem [NREGS];
    logic            w_wr_hit;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign w_wr_hit = bus.io_wr_en && (bus.io_wr_addr != REG_ZERO);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_mem[i] <= '0;
        end else if (w_wr_hit) begin
            r_mem[bus.io_wr_addr] <= bus.io_wr_data;
        end
    end

    always_comb begin
        w_rs1_data = r_mem[bus.io_rs1_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_hit && bus.io_wr_addr == bus.io_rs1_addr)
            w_rs1_data = bus.io_wr_data;
`endif
        if (bus.io_rs1_addr == REG_ZERO)
            w_rs1_data = '0;
    end

    always_comb begin
        w_rs2_data = r_mem[bus.io_rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_hit && bus.io_wr_addr == bus.io_rs2_addr)
            w_rs2_data = bus.io_wr_data;
`endif
        if (bus.io_rs2_addr == REG_ZERO)
            w_rs2_data = '0;
    end

    assign bus.io_rs1_data = w_rs1_data;
    assign bus.io_rs2_data = w_rs2_data;

    reg_scoreboard u_sb (
        .clock       (clock),
        .reset       (reset),
        .i_flush     (bus.io_flush),
        .i_busy_set  (bus.io_busy_set),
        .i_busy_addr (bus.io_busy_addr),
        .i_wr_en     (bus.io_wr_en),
        .i_wr_addr   (bus.io_wr_addr),
        .i_rs1_addr  (bus.io_rs1_addr),
        .i_rs2_addr  (bus.io_rs2_addr),
        .o_stall     (bus.io_stall),
        .o_busy_vec  (bus.io_busy_vec)
    );

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Integer register file for the RV32I core. It is the receiving end of the writeback path: it consumes the selected writeback word and its destination, and serves two combinational read ports to decode/execute.
- Adds a pending-load scoreboard, one busy bit per register. A bit is set when a load is issued and cleared when that load's data is written back.
- Drives a stall to decode while a source operand is still in flight.
- Sits between decode (read side) and the writeback mux output (write side).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (index width = log2(NREGS) = 5).

Ports:
- clock  input  1  core clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- io_rs1_addr  input  5  read port 1 index
- io_rs2_addr  input  5  read port 2 index
- io_rs1_data  output  XLEN  read port 1 data
- io_rs2_data  output  XLEN  read port 2 data
- io_wr_en  input  1  writeback strobe
- io_wr_addr  input  5  writeback destination index
- io_wr_data  input  XLEN  writeback word (selected ALU/load/PC+4 result)
- io_busy_set  input  1  load issued this cycle
- io_busy_addr  input  5  destination of the issued load
- io_flush  input  1  pipeline flush, discard all pending-load marks
- io_stall  output  1  a source operand has a pending load
- io_busy_vec  output  NREGS  current scoreboard, debug/observability

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high. On the reset edge, every register is cleared to 0 and every busy bit is cleared to 0.
  - Consequence: after reset, io_rs1_data = io_rs2_data = 0, io_stall = 0, io_busy_vec = 0.
- Reads: combinational from array state, zero-cycle latency. Index 0 always reads 0.
- Writes:
  - When io_wr_en=1 and io_wr_addr!=0, mem[io_wr_addr] <= io_wr_data on the rising edge.
  - The written value is visible to reads in the following cycle. Same-cycle forwarding exists only with the optional feature enabled.
  - Writes to index 0 are discarded.
- Scoreboard, per index i in 1..NREGS-1, next-state priority:
  1. reset → 0
  2. io_flush → 0; flush beats a same-cycle busy_set
  3. io_busy_set && io_busy_addr==i → 1; a new load beats the older load's writeback clear
  4. io_wr_en && io_wr_addr==i → 0
  5. otherwise hold
- busy[0] is constant 0. io_busy_set with io_busy_addr=0 is ignored.
- Stall: io_stall = (busy[rs1] && rs1!=0) || (busy[rs2] && rs2!=0), computed from registered busy state. It is combinational, with no extra latency.
- A write to a register that is not busy is legal and leaves busy at 0.
- Reset asserted mid-operation: the pending write and busy_set in that cycle are dropped. Reset has priority over everything.
- No arithmetic is performed; all widths pass through unchanged.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined (write-through):
  - If io_wr_en=1, io_wr_addr!=0 and io_wr_addr equals a read index, that read port returns io_wr_data in the same cycle.
  - The busy bit of the written index is treated as clear for io_stall in that cycle, so a load-use stall releases one cycle earlier.
- Undefined:
  - Reads return pre-write array contents.
  - io_stall uses the registered busy bits only, so the stall drops in the cycle after writeback.

Decomposition:
- Shared package core_pkg:
  - constants XLEN=32, NREGS=32, REG_IDX_W=5, REG_ZERO=5'd0
  - reg_idx_t typedef
  - writeback-select encodings (WB_MEM=2'h0, WB_ALU=2'h1, WB_PC4=2'h2), so the writeback mux and this block share one definition
- One natural sub-module: reg_scoreboard, which holds the busy vector, priority update and stall compare. The array and read ports stay in reg_file_wb.

Test Plan:
- Reset then read all 32 indices → all 0; io_stall=0; io_busy_vec=0.
- Write x5=0xDEADBEEF, next cycle rs1=5 → 0xDEADBEEF. Write x0=0x12345678, read rs2=0 → 0. Same-cycle read of x5 during the write of 0x1 → old value without REGFILE_BYPASS_EN, 0x1 with it.
- Load-use stall:
  - busy_set x7, next cycle rs2=7 → io_stall=1.
  - Writeback x7=0x55 → with bypass: stall=0 and rs2 data=0x55 in the same cycle; without bypass: stall=1 that cycle, then 0 with data 0x55 the next cycle.
- Simultaneous busy_set x9 and wr x9=0xAA → x9=0xAA and busy[9]=1 afterwards. busy_set x9 plus io_flush → busy[9]=0.
- Set busy on x3,x4,x31, then flush → io_busy_vec=0 and stall=0. busy_set x0 → io_busy_vec stays 0.
- Reset mid-operation: write x10=0xFF and busy_set x11 in the same cycle as reset=1 → x10=0 and busy[11]=0 afterwards.
